// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: raster scan controller for the VGA pixel datapath.
// Divides clk into a pixel-enable strobe, steps the horizontal/vertical scan
// counters and decodes sync, active-video and line/frame boundary strobes.
//
// Ports:
//   clk        in   system clock (only clock)
//   rst        in   synchronous active-high reset
//   pix_en     out  one-clk strobe per pixel period
//   x          out  horizontal counter, 0..H_TOTAL-1 (registered)
//   y          out  vertical counter, 0..V_TOTAL-1 (registered)
//   hsync_n    out  horizontal sync, active low
//   vsync_n    out  vertical sync, active low
//   active     out  high while (x,y) is inside the visible region
//   line_end   out  pulse on the last clk of each line
//   frame_end  out  pulse on the last clk of each frame
module vga_scan_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       active,
    output logic       line_end,
    output logic       frame_end
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_STOP  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_STOP  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div, div_nxt;
    logic [CNT_W-1:0] hcnt, hcnt_nxt;
    logic [CNT_W-1:0] vcnt, vcnt_nxt;
    logic             h_last;

    // With CLK_DIV == 1, DIV_LAST is 0 and div never leaves 0, so the strobe
    // is constantly high, including while reset is held.
    assign pix_en = (div == DIV_LAST);
    assign h_last = (hcnt == H_LAST);

    // Next-state for divider and scan counters.
    always_comb begin
        div_nxt  = div;
        hcnt_nxt = hcnt;
        vcnt_nxt = vcnt;
        if (div == DIV_LAST) begin
            div_nxt = '0;
        end else begin
            div_nxt = div + DIV_ONE;
        end
        if (pix_en) begin
            if (h_last) begin
                hcnt_nxt = '0;
                vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + CNT_ONE;
            end else begin
                hcnt_nxt = hcnt + CNT_ONE;
            end
        end
    end

    // State registers; reset overrides any pending pixel step.
    always_ff @(posedge clk) begin
        if (rst) begin
            div  <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            div  <= div_nxt;
            hcnt <= hcnt_nxt;
            vcnt <= vcnt_nxt;
        end
    end

    assign x = hcnt;
    assign y = vcnt;

    // Zero-latency decodes from the registered counters.
    assign hsync_n   = !((hcnt >= HS_START) && (hcnt < HS_STOP));
    assign vsync_n   = !((vcnt >= VS_START) && (vcnt < VS_STOP));
    assign active    = (hcnt < H_VIS) && (vcnt < V_VIS);
    assign line_end  = pix_en && h_last;
    assign frame_end = line_end && (vcnt == V_LAST);

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Raster scan controller that sequences the pixel datapath for the 640x480 display. Divides the system clock into a pixel-enable strobe, steps the horizontal/vertical scan counters, and decodes sync, active-video and line/frame boundary strobes. Its `x`/`y` outputs drive the `x`/`y` inputs of `videoGen`, and its sync/active outputs go to the VGA DAC/connector alongside `videoGen`'s `r`/`g`/`b`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels); line total `H_TOTAL` = sum = 800
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines); frame total `V_TOTAL` = sum = 525
- `CLK_DIV`, 2, system clocks per pixel (≥1)

- `clk` in 1: system clock; the only clock
- `rst` in 1: synchronous, active-high reset
- `pix_en` out 1: one-`clk` strobe per pixel period
- `x` out 10: horizontal counter, 0..H_TOTAL-1
- `y` out 10: vertical counter, 0..V_TOTAL-1
- `hsync_n` out 1: horizontal sync, active low
- `vsync_n` out 1: vertical sync, active low
- `active` out 1: high while (`x`,`y`) is in the visible region
- `line_end` out 1: one-`clk` pulse on the last `clk` of each line
- `frame_end` out 1: one-`clk` pulse on the last `clk` of each frame

## Operation
- Divider `div` (`$clog2(CLK_DIV)` bits, min 1) counts 0..CLK_DIV-1 and wraps. `pix_en` = (`div` == CLK_DIV-1). When CLK_DIV = 1, `pix_en` is constant 1 (high during reset too).
- `hcnt`/`vcnt` registers update only on `clk` edges where `pix_en` = 1:
  - `hcnt` < H_TOTAL-1: `hcnt`+1
  - `hcnt` = H_TOTAL-1: `hcnt` → 0, and `vcnt` → `vcnt`+1, or 0 when `vcnt` = V_TOTAL-1
- `x` = `hcnt`, `y` = `vcnt`. Both outputs come directly from registers.
- Decodes are combinational from the registered counters:
  - `hsync_n` = 0 iff H_ACTIVE+H_FP ≤ `hcnt` < H_ACTIVE+H_FP+H_SYNC (656..751)
  - `vsync_n` = 0 iff V_ACTIVE+V_FP ≤ `vcnt` < V_ACTIVE+V_FP+V_SYNC (490..491)
  - `active` = (`hcnt` < H_ACTIVE) && (`vcnt` < V_ACTIVE)
  - `line_end` = `pix_en` && `hcnt` = H_TOTAL-1
  - `frame_end` = `line_end` && `vcnt` = V_TOTAL-1
- All arithmetic is unsigned 10-bit. Counters never exceed TOTAL-1 and never wrap modulo 1024.
- Reset values: `div`=0, `hcnt`=0, `vcnt`=0, so `x`=0, `y`=0, `active`=1, `hsync_n`=1, `vsync_n`=1, `line_end`=0, `frame_end`=0. `pix_en`=0 unless CLK_DIV=1.
- Reset mid-frame: the next edge with `rst`=1 forces every register to its reset value regardless of `pix_en`. No partial line and no spurious strobe follow.

## Timing
- Each `hcnt` value persists for exactly CLK_DIV `clk` cycles. The line period is H_TOTAL×CLK_DIV = 1600 clk. The frame period is V_TOTAL×line = 840 000 clk.
- After `rst` is released (first edge with `rst`=0 counts as cycle 1), `pix_en` is first high during cycle CLK_DIV. `hcnt` first becomes 1 after that edge.
- `line_end`, `frame_end` and `pix_en` are high during the same `clk`. The counter wrap takes effect on the following edge.
- Decode latency: zero cycles relative to `x`/`y`. A downstream registered `videoGen` stage adds its own latency; that latency is compensated outside this block.

## Test plan
- Reset: hold `rst`=1 for 3 clk, sample after an edge → `x`=0, `y`=0, `active`=1, `hsync_n`=1, `vsync_n`=1, `line_end`=0, `frame_end`=0, `pix_en`=0.
- Strobe cadence (CLK_DIV=2): release `rst`, run 10 clk → `pix_en` alternates 0,1,0,1…. `x` increments every 2 clk, and `x`=5 after 10 clk.
- Horizontal timing: run one line → `active` falls as `x` goes 639→640. `hsync_n`=0 for exactly 192 clk (`x` 656..751). `line_end` pulses once at `x`=799. Then `x`=0 and `y`=1.
- Vertical/frame wrap: run 840 000 clk → `vsync_n`=0 for exactly 3200 clk (`y` 490..491). `frame_end` pulses exactly once at (799,524). The next pixel is (0,0). The next `frame_end` comes 840 000 clk later.
- Reset mid-frame: at `x`=700, `y`=300 (inside hsync), assert `rst` for 1 clk → next sample is `x`=0, `y`=0, `hsync_n`=1. Normal cadence resumes, with `pix_en` first high CLK_DIV clk after release.
- CLK_DIV=1 build: `pix_en` stays 1 and `x` increments every clk. The line period is 800 clk.
